// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Multi-cycle control FSM that moves each instruction through
//   IF -> ID -> EX -> MEM -> WB and drives the 16-bit PC register.
//   The PC register sits outside this block: PCWre/newAddress feed it
//   and its output comes back in on currentAddress.
//
// Parameters
//   STEP            address increment per sequential instruction (mod 2^16)
//
// Ports
//   CLK             rising-edge clock
//   RESET           asynchronous, active-low reset
//   currentAddress  current PC value
//   imem_ready      instruction memory data valid this cycle (used in IF only)
//   dmem_ready      data memory access completes this cycle (used in MEM only)
//   op_class        decoded class, sampled in ID
//                   0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP, 5 HALT, 6/7 ALU
//   imm             branch offset (signed) or absolute jump target, sampled in ID
//   zero            ALU zero flag, sampled in EX
//   imem_req        instruction fetch request
//   IRWre           instruction register write strobe
//   dmem_req        data memory request
//   dmem_we         data memory write (store)
//   RegWre          register file write strobe
//   PCWre           PC write enable
//   newAddress      next PC value (seq whenever PCWre is low)
//   state           current FSM state (debug)
//   halted          FSM is parked in HALT
module pc_sequencer #(
  parameter int STEP = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] currentAddress,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic [2:0]  op_class,
  input  logic [15:0] imm,
  input  logic        zero,
  output logic        imem_req,
  output logic        IRWre,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        RegWre,
  output logic        PCWre,
  output logic [15:0] newAddress,
  output logic [2:0]  state,
  output logic        halted
);

  // State encoding (visible on the debug port, so keep these codes stable)
  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  // Instruction classes
  localparam logic [2:0] OP_ALU    = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_STORE  = 3'd2;
  localparam logic [2:0] OP_BRANCH = 3'd3;
  localparam logic [2:0] OP_JUMP   = 3'd4;
  localparam logic [2:0] OP_HALT   = 3'd5;

  localparam logic [15:0] STEP_W = 16'(STEP);

  logic [2:0]  state_q, state_d;
  logic [2:0]  op_q;
  logic [15:0] imm_q;
  logic [2:0]  op_norm;
  logic [15:0] seq, br;

  // Unused class codes 6/7 collapse to ALU before anything looks at them,
  // so op_q only ever holds one of the six real classes.
  assign op_norm = (op_class > OP_HALT) ? OP_ALU : op_class;

  // Both adds wrap naturally at 16 bits; imm_q is a two's-complement offset.
  assign seq = currentAddress + STEP_W;
  assign br  = seq + imm_q;

  assign state = state_q;

  // Next state and strobes. Everything is a function of the current state
  // and the ready/flag inputs, then forced quiet while RESET is low so that
  // an in-flight request or PC write is dropped the moment reset falls.
  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    IRWre      = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    RegWre     = 1'b0;
    PCWre      = 1'b0;
    newAddress = seq;
    halted     = 1'b0;

    case (state_q)
      S_IF: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          IRWre   = 1'b1;
          state_d = S_ID;
        end
      end

      // op_q is still loading on this edge, so ID decides on the live inputs.
      S_ID: begin
        case (op_norm)
          OP_JUMP: begin
            PCWre      = 1'b1;
            newAddress = imm;
            state_d    = S_IF;
          end
          OP_HALT: state_d = S_HALT;
          default: state_d = S_EX;
        endcase
      end

      S_EX: begin
        case (op_q)
          OP_BRANCH: begin
            PCWre      = 1'b1;
            newAddress = zero ? br : seq;
            state_d    = S_IF;
          end
          OP_LOAD, OP_STORE: state_d = S_MEM;
          default:           state_d = S_WB;
        endcase
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op_q == OP_STORE);
        if (dmem_ready) begin
          if (op_q == OP_STORE) begin
            // Stores have nothing to write back: retire straight from MEM.
            PCWre   = 1'b1;
            state_d = S_IF;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        RegWre  = 1'b1;
        PCWre   = 1'b1;
        state_d = S_IF;
      end

      // Parked until reset; no strobes, no PC movement.
      S_HALT: halted = 1'b1;

      // Illegal codes 6/7: silent recovery to fetch.
      default: state_d = S_IF;
    endcase

    if (!RESET) begin
      imem_req   = 1'b0;
      IRWre      = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      RegWre     = 1'b0;
      PCWre      = 1'b0;
      halted     = 1'b0;
      newAddress = seq;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IF;
      op_q    <= OP_ALU;
      imm_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID) begin
        op_q  <= op_norm;
        imm_q <= imm;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [15:0] currentAddress = 16'h0000;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic [2:0]  op_class = 3'd0;
  logic [15:0] imm = 16'h0000;
  logic        zero = 1'b0;
  logic        imem_req, IRWre, dmem_req, dmem_we, RegWre, PCWre, halted;
  logic [15:0] newAddress;
  logic [2:0]  state;

  int tests = 0;
  int fails = 0;

  // {imem_req, IRWre, dmem_req, dmem_we, RegWre, PCWre, halted}
  logic [6:0] sv;
  assign sv = {imem_req, IRWre, dmem_req, dmem_we, RegWre, PCWre, halted};

  pc_sequencer #(.STEP(1)) dut (
    .CLK(CLK), .RESET(RESET), .currentAddress(currentAddress),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .op_class(op_class),
    .imm(imm), .zero(zero), .imem_req(imem_req), .IRWre(IRWre),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .RegWre(RegWre), .PCWre(PCWre),
    .newAddress(newAddress), .state(state), .halted(halted)
  );

  always #5 CLK = ~CLK;

  localparam logic [6:0] S_NONE = 7'b0000000;
  localparam logic [6:0] S_FET  = 7'b1100000;
  localparam logic [6:0] S_FWT  = 7'b1000000;
  localparam logic [6:0] S_WBK  = 7'b0000110;
  localparam logic [6:0] S_PCW  = 7'b0000010;
  localparam logic [6:0] S_LDW  = 7'b0010000;
  localparam logic [6:0] S_STR  = 7'b0011010;
  localparam logic [6:0] S_HLT  = 7'b0000001;

  // Time convention: tasks are entered at posedge+1 with the FSM in IF.
  // Inputs are driven there and outputs checked 1 time unit later.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset_alu();
    logic [6:0] es [4];
    logic [2:0] st [4];
    es = '{S_FET, S_NONE, S_NONE, S_WBK};
    st = '{3'd0, 3'd1, 3'd2, 3'd4};
    RESET = 1'b0; currentAddress = 16'h0010; op_class = 3'd0;
    imem_ready = 1'b1; dmem_ready = 1'b1; imm = 16'h0000; zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #2;
      tests++;
      if ({state, sv, newAddress} !== {3'd0, S_NONE, 16'h0011}) begin
        fails++;
        $display("FAIL reset cyc%0d state/strobes/addr got %h/%b/%h exp 0/0000000/0011",
                 i, state, sv, newAddress);
      end
    end
    @(posedge CLK); #1;
    RESET = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if ({state, sv} !== {st[i], es[i]}) begin
        fails++;
        $display("FAIL alu cyc%0d state/strobes got %0d/%b exp %0d/%b", i + 1, state, sv, st[i], es[i]);
      end
      if (i == 3) begin
        tests++;
        if (newAddress !== 16'h0011) begin
          fails++;
          $display("FAIL alu newAddress got %h exp 0011", newAddress);
        end
      end
      next_cycle();
    end
    tests++;
    if (state !== 3'd0) begin
      fails++;
      $display("FAIL alu return-to-IF state got %0d exp 0", state);
    end
  endtask

  task automatic test_branch(input logic z, input logic [15:0] exp_addr);
    logic [6:0] es [3];
    logic [2:0] st [3];
    es = '{S_FET, S_NONE, S_PCW};
    st = '{3'd0, 3'd1, 3'd2};
    currentAddress = 16'h0020; imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      // op/imm only meaningful in ID, zero only in EX: scramble elsewhere
      op_class = (i == 1) ? 3'd3 : 3'd4;
      imm      = (i == 1) ? 16'hFFF0 : 16'h1234;
      zero     = (i == 2) ? z : ~z;
      #1;
      tests++;
      if ({state, sv} !== {st[i], es[i]}) begin
        fails++;
        $display("FAIL branch z=%0d cyc%0d state/strobes got %0d/%b exp %0d/%b", z, i + 1, state, sv, st[i], es[i]);
      end
      if (i == 2) begin
        tests++;
        if (newAddress !== exp_addr) begin
          fails++;
          $display("FAIL branch z=%0d newAddress got %h exp %h", z, newAddress, exp_addr);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_jump_wrap();
    // JUMP: IF, ID(PCWre)
    currentAddress = 16'h0100; imem_ready = 1'b1; op_class = 3'd4; imm = 16'hABCD;
    #1;
    tests++;
    if ({state, sv} !== {3'd0, S_FET}) begin
      fails++;
      $display("FAIL jump cyc1 state/strobes got %0d/%b exp 0/%b", state, sv, S_FET);
    end
    next_cycle(); #1;
    tests++;
    if ({state, sv, newAddress} !== {3'd1, S_PCW, 16'hABCD}) begin
      fails++;
      $display("FAIL jump cyc2 state/strobes/addr got %0d/%b/%h exp 1/%b/abcd", state, sv, newAddress, S_PCW);
    end
    next_cycle();
    tests++;
    if (state !== 3'd0) begin
      fails++;
      $display("FAIL jump return-to-IF state got %0d exp 0", state);
    end
    // ALU via unused class code 7 at the top of the address space
    currentAddress = 16'hFFFF; op_class = 3'd7;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (i == 3) begin
        tests++;
        if ({state, sv, newAddress} !== {3'd4, S_WBK, 16'h0000}) begin
          fails++;
          $display("FAIL wrap WB state/strobes/addr got %0d/%b/%h exp 4/%b/0000", state, sv, newAddress, S_WBK);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_mem_waits();
    logic [6:0] es [10];
    logic [2:0] st [10];
    int dreq;
    es = '{S_FWT, S_FWT, S_FET, S_NONE, S_NONE, S_LDW, S_LDW, S_LDW, S_LDW, S_WBK};
    st = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
    dreq = 0;
    currentAddress = 16'h0040; op_class = 3'd1; imm = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      imem_ready = (i >= 2 && i < 5) ? 1'b1 : (i >= 5);   // ignored outside IF
      dmem_ready = (i >= 8) || (i < 5);                    // ignored outside MEM
      if (i < 2) imem_ready = 1'b0;
      #1;
      if (dmem_req) dreq++;
      tests++;
      if ({state, sv} !== {st[i], es[i]}) begin
        fails++;
        $display("FAIL load cyc%0d state/strobes got %0d/%b exp %0d/%b", i + 1, state, sv, st[i], es[i]);
      end
      next_cycle();
    end
    tests++;
    if (dreq !== 4 || state !== 3'd0) begin
      fails++;
      $display("FAIL load dmem_req-cycles/end-state got %0d/%0d exp 4/0", dreq, state);
    end
    // STORE retires from MEM
    op_class = 3'd2; imem_ready = 1'b1; dmem_ready = 1'b1; currentAddress = 16'h0050;
    repeat (3) next_cycle();
    #1;
    tests++;
    if ({state, sv, newAddress} !== {3'd3, S_STR, 16'h0051}) begin
      fails++;
      $display("FAIL store MEM state/strobes/addr got %0d/%b/%h exp 3/%b/0051", state, sv, newAddress, S_STR);
    end
    next_cycle();
    tests++;
    if (state !== 3'd0) begin
      fails++;
      $display("FAIL store skips WB state got %0d exp 0", state);
    end
  endtask

  task automatic test_halt_abort();
    int bad;
    op_class = 3'd5; imem_ready = 1'b1; dmem_ready = 1'b1;
    next_cycle(); #1;
    tests++;
    if ({state, sv} !== {3'd1, S_NONE}) begin
      fails++;
      $display("FAIL halt ID state/strobes got %0d/%b exp 1/%b", state, sv, S_NONE);
    end
    next_cycle();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      op_class = 3'(i); zero = i[0]; imem_ready = i[1]; dmem_ready = i[2];
      #1;
      if ({state, sv} !== {3'd5, S_HLT}) bad++;
      next_cycle();
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL halt hold bad-cycles got %0d exp 0", bad);
    end
    RESET = 1'b0; #1;
    tests++;
    if ({state, sv} !== {3'd0, S_NONE}) begin
      fails++;
      $display("FAIL halt reset state/strobes got %0d/%b exp 0/%b", state, sv, S_NONE);
    end
    next_cycle();
    RESET = 1'b1; imem_ready = 1'b1; op_class = 3'd1; dmem_ready = 1'b0; #1;
    tests++;
    if ({state, sv} !== {3'd0, S_FET}) begin
      fails++;
      $display("FAIL halt restart state/strobes got %0d/%b exp 0/%b", state, sv, S_FET);
    end
    // LOAD parked in MEM, then abort
    repeat (3) next_cycle();
    #1;
    tests++;
    if ({state, sv} !== {3'd3, S_LDW}) begin
      fails++;
      $display("FAIL abort pre state/strobes got %0d/%b exp 3/%b", state, sv, S_LDW);
    end
    #1 dmem_ready = 1'b1;
    #1 RESET = 1'b0;
    #1;
    tests++;
    if ({state, sv} !== {3'd0, S_NONE}) begin
      fails++;
      $display("FAIL abort state/strobes got %0d/%b exp 0/%b", state, sv, S_NONE);
    end
    next_cycle();
    RESET = 1'b1;
  endtask

  initial begin
    test_reset_alu();
    test_branch(1'b1, 16'h0011);
    test_branch(1'b0, 16'h0021);
    test_jump_wrap();
    test_mem_waits();
    test_halt_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
